load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store unit with big-endian lanes and read-modify-write sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses with err.
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  op,
   input  logic [7:0]  addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [7:0]  Address,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [2:0]  r_op;
   logic [7:0]  r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_word;
   logic        r_err;
   logic [31:0] r_rdata;

   logic        w_bad;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   always_comb begin
      w_bad = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((op[1:0] == 2'b01) && addr[0])
         w_bad = 1'b1;
      if ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00))
         w_bad = 1'b1;
`endif
   end

   // Lane k of the bus word sits at bits [31-8k:24-8k].
   always_comb begin
      w_byte = ReadData[31:24];
      unique case (r_addr[1:0])
         2'd0: w_byte = ReadData[31:24];
         2'd1: w_byte = ReadData[23:16];
         2'd2: w_byte = ReadData[15:8];
         2'd3: w_byte = ReadData[7:0];
      endcase
      w_half = r_addr[1] ? ReadData[15:0] : ReadData[31:16];
      case (r_op)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = ReadData;
      endcase
   end

   always_comb begin
      w_merge = r_word;
      case (r_op[1:0])
         2'b00: begin
            unique case (r_addr[1:0])
               2'd0: w_merge[31:24] = r_wdata[7:0];
               2'd1: w_merge[23:16] = r_wdata[7:0];
               2'd2: w_merge[15:8]  = r_wdata[7:0];
               2'd3: w_merge[7:0]   = r_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (r_addr[1])
               w_merge[15:0] = r_wdata[15:0];
            else
               w_merge[31:16] = r_wdata[15:0];
         end
         default: w_merge = r_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_op    <= 3'd0;
         r_addr  <= 8'd0;
         r_wdata <= 32'd0;
         r_word  <= 32'd0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && req) begin
            r_we    <= we;
            r_op    <= op;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_err   <= w_bad;
         end
         if (r_state == RD) begin
            r_word <= ReadData;
            if (!r_we)
               r_rdata <= w_load;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      busy      = (r_state != IDLE);
      done      = 1'b0;
      err       = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = 8'd0;
      WriteData = 32'd0;
      rdata     = r_rdata;
      case (r_state)
         IDLE: begin
            if (req) begin
               if (w_bad)
                  w_next = DONE;
               else if (we && op == 3'b010)
                  w_next = WR;
               else
                  w_next = RD;
            end
         end
         RD: begin
            MemRead = 1'b1;
            Address = {r_addr[7:2], 2'b00};
            w_next  = r_we ? WR : DONE;
         end
         WR: begin
            MemWrite  = 1'b1;
            Address   = {r_addr[7:2], 2'b00};
            WriteData = w_merge;
            w_next    = DONE;
         end
         DONE: begin
            done   = 1'b1;
            err    = r_err;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven scoreboard bench for load_store_unit with a word-wide memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [2:0]  op;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        MemRead, MemWrite;
   logic [7:0]  Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   logic [31:0] mem [64];

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [2:0]  op;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        e_err;
      logic [31:0] e_rdata;
      int          e_lat;
      int          e_rd;
      int          e_wr;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vt [21];
   vec_t sb [$];

   load_store_unit dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .op(op),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
   );

   always #5 clk = ~clk;

   assign ReadData = mem[Address[7:2]];

   always @(posedge clk)
      if (MemWrite)
         mem[Address[7:2]] <= WriteData;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [2:0] o, input logic [7:0] a,
                               input logic [31:0] d, input logic ee, input logic [31:0] er,
                               input int el, input int erd, input int ewr, input logic [31:0] ewd);
      vec_t v;
      v.we = w; v.op = o; v.addr = a; v.wdata = d;
      v.e_err = ee; v.e_rdata = er; v.e_lat = el;
      v.e_rd = erd; v.e_wr = ewr; v.e_wd = ewd;
      return v;
   endfunction

   task automatic run(input vec_t v, input string nm);
      int   lat, nrd, nwr;
      logic got;
      logic [31:0] wd;
      vec_t e;
      @(negedge clk);
      req = 1'b1; we = v.we; op = v.op; addr = v.addr; wdata = v.wdata;
      sb.push_back(v);
      lat = 0; nrd = 0; nwr = 0; got = 1'b0; wd = 32'd0;
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         if (c == 1) req = 1'b0;
         if (MemRead) nrd++;
         if (MemWrite) begin nwr++; wd = WriteData; end
         if (done) begin got = 1'b1; lat = c; end
      end
      e = sb.pop_front();
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_done actual=none required=pulse", nm);
      end else begin
         chk({nm, "_lat"}, 32'(lat), 32'(e.e_lat));
         chk({nm, "_err"}, {31'd0, err}, {31'd0, e.e_err});
         chk({nm, "_rdata"}, rdata, e.e_rdata);
         chk({nm, "_nrd"}, 32'(nrd), 32'(e.e_rd));
         chk({nm, "_nwr"}, 32'(nwr), 32'(e.e_wr));
         if (e.e_wr != 0)
            chk({nm, "_wd"}, wd, e.e_wd);
      end
   endtask

   initial begin
      logic [31:0] r13;
      int nd, nw;
      reset = 1'b1; req = 1'b0; we = 1'b0; op = 3'd0; addr = 8'd0; wdata = 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
      r13 = 32'hFFFFBEEF;
`else
      r13 = 32'hDEAABEEF;
`endif
      vt[0]  = mk(1, 3'b010, 8'h10, 32'h8899AABB, 0, 32'h0, 2, 0, 1, 32'h8899AABB);
      vt[1]  = mk(1, 3'b010, 8'h20, 32'h11223344, 0, 32'h0, 2, 0, 1, 32'h11223344);
      vt[2]  = mk(0, 3'b000, 8'h11, 32'h0, 0, 32'hFFFFFF99, 2, 1, 0, 32'h0);
      vt[3]  = mk(0, 3'b100, 8'h11, 32'h0, 0, 32'h00000099, 2, 1, 0, 32'h0);
      vt[4]  = mk(0, 3'b001, 8'h10, 32'h0, 0, 32'hFFFF8899, 2, 1, 0, 32'h0);
      vt[5]  = mk(0, 3'b101, 8'h12, 32'h0, 0, 32'h0000AABB, 2, 1, 0, 32'h0);
      vt[6]  = mk(0, 3'b000, 8'h13, 32'h0, 0, 32'hFFFFFFBB, 2, 1, 0, 32'h0);
      vt[7]  = mk(1, 3'b001, 8'h22, 32'h0000BEEF, 0, 32'hFFFFFFBB, 3, 1, 1, 32'h1122BEEF);
      vt[8]  = mk(0, 3'b010, 8'h20, 32'h0, 0, 32'h1122BEEF, 2, 1, 0, 32'h0);
      vt[9]  = mk(1, 3'b010, 8'h40, 32'hDEADBEEF, 0, 32'h1122BEEF, 2, 0, 1, 32'hDEADBEEF);
      vt[10] = mk(0, 3'b101, 8'h40, 32'h0, 0, 32'h0000DEAD, 2, 1, 0, 32'h0);
      vt[11] = mk(0, 3'b001, 8'h42, 32'h0, 0, 32'hFFFFBEEF, 2, 1, 0, 32'h0);
      vt[12] = mk(1, 3'b000, 8'h41, 32'h000000AA, 0, 32'hFFFFBEEF, 3, 1, 1, 32'hDEAABEEF);
`ifdef LSU_MISALIGN_TRAP_EN
      vt[13] = mk(0, 3'b010, 8'h41, 32'h0, 1, r13, 1, 0, 0, 32'h0);
`else
      vt[13] = mk(0, 3'b010, 8'h41, 32'h0, 0, r13, 2, 1, 0, 32'h0);
`endif
      vt[14] = mk(0, 3'b011, 8'h40, 32'h0, 1, r13, 1, 0, 0, 32'h0);
      vt[15] = mk(1, 3'b100, 8'h40, 32'h12345678, 1, r13, 1, 0, 0, 32'h0);
      vt[16] = mk(0, 3'b110, 8'h40, 32'h0, 1, r13, 1, 0, 0, 32'h0);
      vt[17] = mk(1, 3'b000, 8'h43, 32'h00000055, 0, r13, 3, 1, 1, 32'hDEAABE55);
      vt[18] = mk(0, 3'b010, 8'h40, 32'h0, 0, 32'hDEAABE55, 2, 1, 0, 32'h0);
      vt[19] = mk(1, 3'b001, 8'h40, 32'hFFFF1234, 0, 32'hDEAABE55, 3, 1, 1, 32'h1234BE55);
      vt[20] = mk(0, 3'b000, 8'h40, 32'h0, 0, 32'h00000012, 2, 1, 0, 32'h0);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      chk("rst_addr", {24'd0, Address}, 32'd0);
      chk("rst_wd", WriteData, 32'd0);

      for (int i = 0; i < 21; i++)
         run(vt[i], $sformatf("v%0d", i));

      // reset while an sb is in RD: no write, no done
      @(negedge clk);
      req = 1'b1; we = 1'b1; op = 3'b000; addr = 8'h10; wdata = 32'h77;
      @(negedge clk);
      req = 1'b0;
      chk("rmw_rd", {31'd0, MemRead}, 32'd1);
      chk("rmw_addr", {24'd0, Address}, 32'h10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rmw_rst_busy", {31'd0, busy}, 32'd0);
      chk("rmw_rst_rdata", rdata, 32'd0);
      chk("rmw_rst_addr", {24'd0, Address}, 32'd0);
      nd = 0; nw = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) nd++;
         if (MemWrite) nw++;
      end
      chk("rmw_rst_done", 32'(nd), 32'd0);
      chk("rmw_rst_wr", 32'(nw), 32'd0);
      run(mk(0, 3'b010, 8'h10, 32'h0, 0, 32'h8899AABB, 2, 1, 0, 32'h0), "rmw_keep");

      // reset at the WR exit edge still lands the write
      @(negedge clk);
      req = 1'b1; we = 1'b1; op = 3'b010; addr = 8'h50; wdata = 32'hCAFEF00D;
      @(negedge clk);
      req = 1'b0;
      chk("sw_rst_wr", {31'd0, MemWrite}, 32'd1);
      chk("sw_rst_wd", WriteData, 32'hCAFEF00D);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("sw_rst_busy", {31'd0, busy}, 32'd0);
      nd = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("sw_rst_done", 32'(nd), 32'd0);
      run(mk(0, 3'b010, 8'h50, 32'h0, 0, 32'hCAFEF00D, 2, 1, 0, 32'h0), "sw_rst_mem");

      // reset wins over a simultaneous req
      @(negedge clk);
      reset = 1'b1; req = 1'b1; we = 1'b0; op = 3'b010; addr = 8'h10;
      @(negedge clk);
      reset = 1'b0; req = 1'b0;
      chk("rst_prio_busy", {31'd0, busy}, 32'd0);

      // req held high: ignored while busy, re-accepted in IDLE
      @(negedge clk);
      req = 1'b1; we = 1'b0; op = 3'b100; addr = 8'h11;
      nd = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done) nd++;
         if (c == 12) req = 1'b0;
      end
      chk("held_dones", 32'(nd), 32'd4);
      chk("held_rdata", rdata, 32'h00000099);
      nd = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("held_quiet", 32'(nd), 32'd0);
      chk("held_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
